// File: rtl/wb_rom_arb.sv
// wb_rom_arb: two-master round-robin Wishbone arbiter in front of the boot/program ROM slave.
// Latency: grant registered one edge after the request; data, address and responses pass through combinationally.
// Backpressure: the non-owner stalls (no ack/err) until the owner drops cyc; a watchdog errors out silent accesses.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   mN_adr/dat/sel/we/cyc/stb_i master N request (N = 0 fetch, 1 load/store)
//   mN_dat_o, mN_ack_o, mN_err_o master N response; read data is broadcast to both
//   s_*_o / s_dat/ack/err_i     single shared slave port
//   gnt_o                       one-hot current owner, 2'b00 when idle
module wb_rom_arb #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,

    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // A zero limit still needs a legal one-bit counter; it is simply held at zero.
    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW-1:0] TMO_C = CW'(TMO);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic req0, req1;
    logic tmo_hit;
    logic err_raw;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;    // master 0 wins the first tie
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: round-robin only from IDLE; the owner keeps the slave for its whole cycle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0:    if (!m0_cyc_i) state_d = IDLE;
            GNT1:    if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Watchdog only runs while the slave is actually strobed and silent;
        // a hit clears the count so the error repeats every TMO+1 cycles.
        cnt_d = cnt_q;
        if (TMO == 0) begin
            cnt_d = '0;
        end else if ((state_d != state_q) || s_ack_i || s_err_i || !s_stb_o || tmo_hit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Outputs: slave-side mux and owner-only responses.
    always_comb begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        gnt_o   = 2'b00;
        case (state_q)
            GNT0: begin
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                gnt_o   = 2'b01;
            end
            GNT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                gnt_o   = 2'b10;
            end
            default: ;
        endcase

        tmo_hit = (TMO != 0) && s_stb_o && (cnt_q == TMO_C);
        // A real ack arriving on the timeout cycle takes precedence over the watchdog error.
        err_raw = (s_err_i & s_stb_o) | (tmo_hit & ~s_ack_i);

        m0_ack_o = (state_q == GNT0) & s_ack_i & s_stb_o;
        m1_ack_o = (state_q == GNT1) & s_ack_i & s_stb_o;
        m0_err_o = (state_q == GNT0) & err_raw;
        m1_err_o = (state_q == GNT1) & err_raw;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
    end

endmodule

// File: tb/tb_wb_rom_arb.sv
// tb_wb_rom_arb: self-checking bench for wb_rom_arb with a registered-ack ROM slave model.
// Read data is checked through per-master expected-data queues popped on each ack.
// Grant, stall, error, watchdog and reset behaviour are checked inline per scenario.
module tb_wb_rom_arb;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic [AW-1:0] m0_adr_i = '0, m1_adr_i = '0;
    logic [DW-1:0] m0_dat_i = '0, m1_dat_i = '0;
    logic [3:0]    m0_sel_i = 4'hF, m1_sel_i = 4'hF;
    logic          m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic          m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
    logic          m0_stb_i = 1'b0, m1_stb_i = 1'b0;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i;
    logic [1:0]    gnt_o;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    // ROM slave model: registered ack every strobed cycle, error on writes, mute when rom_en = 0.
    logic          rom_en  = 1'b1;
    logic          rom_ack = 1'b0;
    logic          rom_err = 1'b0;
    logic [DW-1:0] rom_dat = '0;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] adr);
        logic [7:0] w;
        w = adr[9:2];
        return {8'hC0, w, ~w, w ^ 8'h5A};
    endfunction

    always @(posedge wb_clk_i) begin
        rom_ack <= s_cyc_o & s_stb_o & ~s_we_o & rom_en;
        rom_err <= s_cyc_o & s_stb_o & s_we_o & rom_en;
        rom_dat <= rom_word(s_adr_o);
    end
    assign s_ack_i = rom_ack;
    assign s_err_i = rom_err;
    assign s_dat_i = rom_dat;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_rom_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o)
    );

    // Scoreboard: every ack must match the oldest expected word queued for that master.
    always @(negedge wb_clk_i) begin : scoreboard
        logic [DW-1:0] exp_dat;
        if (!wb_rst_i) begin
            if (m0_ack_o === 1'b1) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL m0_unexpected_ack got ack=1 want no pending read");
                end else begin
                    exp_dat = q0.pop_front();
                    if (m0_dat_o !== exp_dat) begin
                        failures++;
                        $display("FAIL m0_read_data got %h want %h", m0_dat_o, exp_dat);
                    end
                end
            end
            if (m1_ack_o === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL m1_unexpected_ack got ack=1 want no pending read");
                end else begin
                    exp_dat = q1.pop_front();
                    if (m1_dat_o !== exp_dat) begin
                        failures++;
                        $display("FAIL m1_read_data got %h want %h", m1_dat_o, exp_dat);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge wb_clk_i);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, gnt_o} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got cyc=%b stb=%b we=%b ack=%b%b err=%b%b gnt=%b want all 0",
                     s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, gnt_o);
        end
        tick();
        wb_rst_i = 1'b0;
        smp();
        checks++;
        if (gnt_o !== 2'b00) begin failures++; $display("FAIL reset_idle got gnt=%b want 00", gnt_o); end
    endtask

    task automatic test_tie();
        tick();
        m0_adr_i = 32'h14; m1_adr_i = 32'h18;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        q0.push_back(rom_word(32'h14));
        smp();
        smp();
        checks++;
        if (gnt_o !== 2'b01) begin failures++; $display("FAIL tie_first got gnt=%b want 01", gnt_o); end
        smp();
        checks++;
        if (m0_ack_o !== 1'b1) begin failures++; $display("FAIL tie_m0_ack got %b want 1", m0_ack_o); end
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        q1.push_back(rom_word(32'h18));
        smp();
        smp();
        checks++;
        if (gnt_o !== 2'b00) begin failures++; $display("FAIL tie_dead_cycle got gnt=%b want 00", gnt_o); end
        smp();
        checks++;
        if (gnt_o !== 2'b10) begin failures++; $display("FAIL tie_second got gnt=%b want 10", gnt_o); end
        smp();
        checks++;
        if (m1_ack_o !== 1'b1) begin failures++; $display("FAIL tie_m1_ack got %b want 1", m1_ack_o); end
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        smp();
        smp();
        tick();
        m0_adr_i = 32'h1C; m1_adr_i = 32'h18;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        q0.push_back(rom_word(32'h1C));
        smp();
        smp();
        checks++;
        if (gnt_o !== 2'b01) begin failures++; $display("FAIL tie_alternate got gnt=%b want 01", gnt_o); end
        smp();
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        smp();
        smp();
    endtask

    task automatic test_single_fetch();
        tick();
        m0_adr_i = 32'h10; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        q0.push_back(rom_word(32'h10));
        smp();
        checks++;
        if (s_stb_o !== 1'b0) begin failures++; $display("FAIL fetch_req_cycle got stb=%b want 0", s_stb_o); end
        smp();
        checks++;
        if (s_stb_o !== 1'b1 || gnt_o !== 2'b01 || s_adr_o !== 32'h10 || m0_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL fetch_grant got stb=%b gnt=%b adr=%h ack=%b want 1 01 10 0", s_stb_o, gnt_o, s_adr_o, m0_ack_o);
        end
        smp();
        checks++;
        if (m0_ack_o !== 1'b1) begin failures++; $display("FAIL fetch_ack got %b want 1", m0_ack_o); end
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        smp();
        checks++;
        if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL fetch_ack_masked got %b want 0", m0_ack_o); end
        smp();
        checks++;
        if (gnt_o !== 2'b00) begin failures++; $display("FAIL fetch_release got gnt=%b want 00", gnt_o); end
    endtask

    task automatic test_locked_burst();
        int t;
        tick();
        m1_adr_i = 32'h100; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (t = 0; t < 10; t++) begin
            smp();
            if (gnt_o === 2'b10) break;
        end
        checks++;
        if (gnt_o !== 2'b10) begin failures++; $display("FAIL burst_grant_timeout got gnt=%b want 10", gnt_o); end
        q1.push_back(rom_word(32'h100));
        m0_adr_i = 32'h20; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        q0.push_back(rom_word(32'h20));
        for (int i = 1; i <= 8; i++) begin
            tick();
            m1_adr_i = 32'h100 + 32'(4 * i);
            if (i < 8) q1.push_back(rom_word(m1_adr_i));
            smp();
            checks++;
            if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || gnt_o !== 2'b10) begin
                failures++;
                $display("FAIL burst_beat%0d got m1_ack=%b m0_ack=%b gnt=%b want 1 0 10", i, m1_ack_o, m0_ack_o, gnt_o);
            end
        end
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        smp();
        checks++;
        if (m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL burst_release_acks got m1_ack=%b m0_ack=%b want 0 0", m1_ack_o, m0_ack_o);
        end
        smp();
        checks++;
        if (gnt_o !== 2'b00) begin failures++; $display("FAIL burst_dead_cycle got gnt=%b want 00", gnt_o); end
        smp();
        checks++;
        if (gnt_o !== 2'b01) begin failures++; $display("FAIL burst_regrant got gnt=%b want 01", gnt_o); end
        smp();
        checks++;
        if (m0_ack_o !== 1'b1) begin failures++; $display("FAIL burst_m0_ack got %b want 1", m0_ack_o); end
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        smp();
        smp();
    endtask

    task automatic test_rom_write();
        int t;
        tick();
        m1_adr_i = 32'h40; m1_dat_i = 32'hDEADBEEF; m1_we_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (t = 0; t < 10; t++) begin
            smp();
            if (gnt_o === 2'b10) break;
        end
        checks++;
        if (gnt_o !== 2'b10 || s_we_o !== 1'b1 || s_dat_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_grant got gnt=%b we=%b dat=%h want 10 1 deadbeef", gnt_o, s_we_o, s_dat_o);
        end
        smp();
        checks++;
        if (m1_err_o !== 1'b1 || m0_err_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL write_err got m1_err=%b m0_err=%b m1_ack=%b want 1 0 0", m1_err_o, m0_err_o, m1_ack_o);
        end
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        smp();
        smp();
        checks++;
        if (gnt_o !== 2'b00) begin failures++; $display("FAIL write_release got gnt=%b want 00", gnt_o); end
    endtask

    task automatic test_watchdog();
        int t;
        logic exp_err;
        tick();
        rom_en = 1'b0;
        m0_adr_i = 32'h30; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (t = 0; t < 10; t++) begin
            smp();
            if (gnt_o === 2'b01) break;
        end
        checks++;
        if (gnt_o !== 2'b01) begin failures++; $display("FAIL wdog_grant_timeout got gnt=%b want 01", gnt_o); end
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) smp();
            exp_err = (i == 4) || (i == 9);
            checks++;
            if (m0_err_o !== exp_err || m1_err_o !== 1'b0) begin
                failures++;
                $display("FAIL wdog_cycle%0d got m0_err=%b m1_err=%b want %b 0", i, m0_err_o, m1_err_o, exp_err);
            end
        end
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        smp();
        smp();
        checks++;
        if (gnt_o !== 2'b00 || m0_err_o !== 1'b0) begin
            failures++;
            $display("FAIL wdog_release got gnt=%b err=%b want 00 0", gnt_o, m0_err_o);
        end
        rom_en = 1'b1;
    endtask

    task automatic test_reset_mid_grant();
        int t;
        tick();
        m1_adr_i = 32'h44; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (t = 0; t < 10; t++) begin
            smp();
            if (gnt_o === 2'b10) break;
        end
        q1.push_back(rom_word(32'h44));
        smp();
        checks++;
        if (m1_ack_o !== 1'b1) begin failures++; $display("FAIL rst_pre_ack got %b want 1", m1_ack_o); end
        #2;
        wb_rst_i = 1'b1;
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, m1_ack_o, m1_err_o, gnt_o} !== 6'b0) begin
            failures++;
            $display("FAIL rst_async got cyc=%b stb=%b we=%b ack=%b err=%b gnt=%b want all 0",
                     s_cyc_o, s_stb_o, s_we_o, m1_ack_o, m1_err_o, gnt_o);
        end
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        #2;
        wb_rst_i = 1'b0;
        tick();
        m0_adr_i = 32'h48; m1_adr_i = 32'h4C;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        q0.push_back(rom_word(32'h48));
        smp();
        smp();
        checks++;
        if (gnt_o !== 2'b01) begin failures++; $display("FAIL rst_tie got gnt=%b want 01", gnt_o); end
        smp();
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        smp();
        smp();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_fetch();
        test_locked_burst();
        test_rom_write();
        test_watchdog();
        test_reset_mid_grant();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL pending_reads got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/wb_rom_arb.md
# wb_rom_arb

Two-master Wishbone arbiter that shares the single boot/program ROM slave between the instruction-fetch port (master 0) and the load/store port (master 1). It sits between the core's two bus masters and the ROM's Wishbone slave port. It grants the slave to one master at a time with round-robin fairness, holds the grant for the master's whole cycle, and routes ack/err back only to the owner. A watchdog terminates any granted access the slave never answers.

## Interface
Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TMO, 16, watchdog limit in cycles; 0 disables the watchdog.

Ports (N = 0, 1; one set per master):
- wb_clk_i  input  1  clock.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- mN_adr_i  input  AW  master N address.
- mN_dat_i  input  DW  master N write data.
- mN_sel_i  input  4  master N byte select.
- mN_we_i  input  1  master N write enable.
- mN_cyc_i  input  1  master N cycle.
- mN_stb_i  input  1  master N strobe.
- mN_dat_o  output  DW  read data; equals s_dat_i, broadcast to both masters.
- mN_ack_o  output  1  master N acknowledge.
- mN_err_o  output  1  master N error.
- s_adr_o  output  AW  slave address.
- s_dat_o  output  DW  slave write data.
- s_sel_o  output  4  slave byte select.
- s_we_o  output  1  slave write enable.
- s_cyc_o  output  1  slave cycle.
- s_stb_o  output  1  slave strobe.
- s_dat_i  input  DW  slave read data.
- s_ack_i  input  1  slave acknowledge.
- s_err_i  input  1  slave error.
- gnt_o  output  2  one-hot current grant, for debug; 2'b00 when idle.

## Operation
- Registered state: FSM state {IDLE, GNT0, GNT1}, last_r (last granted master, 1 bit), and a watchdog counter of clog2(TMO+1) bits.
- Request: reqN = mN_cyc_i & mN_stb_i.
- Transitions out of IDLE:
  - req0 only: go to GNT0.
  - req1 only: go to GNT1.
  - Both requesting: grant the master != last_r.
  - On each grant, last_r takes the granted index.
- GNTn: stay while mn_cyc_i = 1. When mn_cyc_i = 0, go to IDLE. The other master's request is never honoured directly from GNTn.
- Slave-side mux:
  - In GNTn: s_adr/dat/sel/we/cyc/stb_o = master n's inputs.
  - In IDLE: s_cyc_o = s_stb_o = s_we_o = 0, and adr/dat/sel come from master 0.
- Master-side responses:
  - In GNTn: mn_ack_o = s_ack_i & s_stb_o and mn_err_o = (s_err_i & s_stb_o) | tmo_hit.
  - The non-owner's ack_o and err_o are 0 at all times.
- Slave errors, including ROM write-rejection errors, pass through unchanged. The arbiter does not decode addresses or writes.
- Watchdog, active only when TMO != 0:
  - Counter clears on any state change, on s_ack_i, on s_err_i, or when s_stb_o = 0.
  - Otherwise it increments each cycle while in GNTn with s_stb_o = 1.
  - tmo_hit = (counter == TMO), combinational. It produces a one-cycle owner err_o, and the counter clears on the next edge.
  - If s_ack_i and tmo_hit coincide, ack wins: err_o is suppressed that cycle.
- Reset, including mid-transfer: state = IDLE, last_r = 1 so master 0 wins the first tie, counter = 0. All s_cyc/stb/we_o, mN_ack_o, mN_err_o and gnt_o are 0 immediately on wb_rst_i assertion.

## Timing
- Grant latency: a request seen in IDLE at edge k produces GNTn from edge k, so s_stb_o is high in cycle k+1.
- End-to-end read:
  - ROM registered ack arrives in cycle k+2.
  - mn_ack_o is combinational from s_ack_i, also in cycle k+2.
  - First-access latency is 2 cycles after request.
- Back-to-back accesses by the owner while holding cyc: one ack per cycle. The slave sees stb continuously, with pass-through latency of 0 arbiter cycles.
- Release: owner drops cyc in cycle j. The arbiter is IDLE in j+1 and the next grant appears in j+2, giving one dead cycle between owners.
- mN_dat_o and s_* address/data outputs are combinational. The arbiter adds no pipeline register on data.

## Test plan
- **Single fetch:** m0 reads adr 0x10 with cyc/stb held high. Required: s_stb_o rises 1 cycle later, m0_ack_o 2 cycles after request with m0_dat_o = ROM word 4, m1_ack_o = 0 throughout.
- **Simultaneous requests after reset:** both masters request together. Required:
  - m0 is granted first (gnt_o = 01).
  - After m0 drops cyc, one dead cycle follows, then gnt_o = 10.
  - Repeating the tie grants m0 again (alternation).
- **Locked burst:** m1 holds cyc for 8 sequential reads while m0 requests. Required: 8 m1 acks on consecutive cycles, m0 stalled with no ack, m0 granted 2 cycles after m1 releases.
- **Write to ROM:** m1 issues we = 1. Required: m1_err_o = 1 when the slave reports its error, m0_err_o = 0, grant released normally.
- **Watchdog:** TMO = 4, slave ack/err tied low, m0 requests. Required:
  - m0_err_o pulses exactly once, 4 cycles after s_stb_o rises.
  - It repeats every 5 cycles while stb is held.
  - Dropping cyc returns the arbiter to IDLE.
- **Reset mid-grant:** assert wb_rst_i during GNT1. Required:
  - s_cyc_o, s_stb_o, m1_ack_o and gnt_o go to 0 without waiting for a clock edge.
  - After release, a tie grants m0 first.
